// File: rtl/ft2232h_tx_fifo.sv
// FT2232H synchronous-FIFO transmitter with an internal byte FIFO.
// User bytes enter through a valid/ready port, drain to the device under
// TXE# flow control, and an idle timer issues a single SIWU# flush per burst.
module ft2232h_tx_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FLUSH_IDLE = 8,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              txe_n,
  output logic              wr_n,
  output logic [7:0]        data_out,
  output logic              rd_n,
  output logic              oe_n,
  output logic              siwu_n,
  output logic [ADDR_W:0]   level,
  output logic [CNT_W-1:0]  tx_count
);

  localparam int unsigned LvlW  = ADDR_W + 1;
  // Idle counter only needs to reach FLUSH_IDLE.
  localparam int unsigned IdleW = (FLUSH_IDLE < 2) ? 1 : $clog2(FLUSH_IDLE + 1);

  localparam logic [LvlW-1:0]  LevelFull = LvlW'(DEPTH);
  localparam logic [IdleW-1:0] IdleMax   = IdleW'(FLUSH_IDLE);

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StFlush
  } flush_state_e;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [LvlW-1:0]   level_q;
  logic [LvlW-1:0]   level_d;
  logic [CNT_W-1:0]  tx_count_q;
  logic              wr_n_q;
  logic              wr_n_d;
  logic              siwu_n_q;
  logic              siwu_n_d;
  flush_state_e      state_q;
  flush_state_e      state_d;
  logic [IdleW-1:0]  idle_q;
  logic [IdleW-1:0]  idle_d;
  logic              push;
  logic              pop;

  // Ready is held low during reset and never anticipates a same-cycle pop.
  assign in_ready = reset_n & (level_q < LevelFull);
  assign push     = in_valid & in_ready;
  // The device takes a byte only when both strobes are low at the edge.
  assign pop      = ~wr_n_q & ~txe_n;

  assign data_out = mem_q[rd_ptr_q];
  assign wr_n     = wr_n_q;
  assign siwu_n   = siwu_n_q;
  assign rd_n     = 1'b1;
  assign oe_n     = 1'b1;
  assign level    = level_q;
  assign tx_count = tx_count_q;

  // Occupancy after this edge and the write-strobe decision that depends on it.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
    // Looking at the post-edge level keeps the strobe low across back-to-back bytes.
    wr_n_d = ~(enable & ~txe_n & (level_d != '0));
  end

  // Byte storage; not reset, a reset simply discards contents via the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Pointers, occupancy, write strobe and accepted-byte counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tx_count_q <= '0;
      wr_n_q     <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + ADDR_W'(1);
        tx_count_q <= tx_count_q + CNT_W'(1);
      end
      level_q <= level_d;
      wr_n_q  <= wr_n_d;
    end
  end

  // Auto-flush next state: arm on a transfer, count quiet cycles, pulse once.
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StArmed;
          idle_d  = '0;
        end
      end
      StArmed: begin
        if (push || pop) begin
          idle_d = '0;
        end else if ((level_q == '0) && wr_n_q) begin
          idle_d = idle_q + IdleW'(1);
          if (idle_d == IdleMax) begin
            state_d = StFlush;
            idle_d  = '0;
          end
        end
      end
      // The pulse always completes; a push here does not cancel it.
      StFlush: begin
        state_d = StIdle;
        idle_d  = '0;
      end
      default: begin
        state_d = StIdle;
        idle_d  = '0;
      end
    endcase
    if (FLUSH_IDLE == 0) begin
      state_d = StIdle;
      idle_d  = '0;
    end
    siwu_n_d = (state_d != StFlush);
  end

  // Auto-flush state register and registered SIWU# output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      idle_q   <= '0;
      siwu_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      siwu_n_q <= siwu_n_d;
    end
  end

endmodule
